id_ex_pipeline_reg: RTL and testbench
=====================================

Name: id_ex_pipeline_reg

Overview:
Decode-to-execute pipeline register of the 5-stage RV32I core. It captures the decode-stage control bundle from the control unit, plus register-file read data, the extended immediate, PC and register indices. It presents them to the execute stage one cycle later. It supports a stall (hold) from the hazard unit and a flush (bubble insert) on branch/jump redirect or load-use hazard, and tracks a per-entry valid bit.

Parameters:
DATA_WIDTH, 32, width of rd1/rd2/imm/pc fields
REG_ADDR_WIDTH, 5, width of rs1/rs2/rd indices

Ports:
clk  in  1  core clock, rising-edge
rst  in  1  synchronous active-high reset
stall_e_i  in  1  hold current contents (enable low)
flush_e_i  in  1  load bubble on next edge
valid_d_i  in  1  decode stage holds a real instruction
reg_write_d_i  in  1  control: register write
result_src_d_i  in  2  control: 00 ALU, 01 mem, 10 pc+4
mem_write_d_i  in  1  control: store
jump_d_i  in  1  control: jal/jalr
branch_d_i  in  1  control: conditional branch
alu_src_d_i  in  1  control: ALU B = imm
alu_control_d_i  in  ALU_CONTROL_WIDTH  ALU op
funct3_d_i  in  3  branch/load/store sub-op
op_a_sel_d_i  in  alu_a_src_sel_e  ALU A source
pc_target_src_sel_d_i  in  pc_target_src_sel_e  branch target source
rd1_d_i, rd2_d_i  in  DATA_WIDTH  register read data
imm_ext_d_i  in  DATA_WIDTH  extended immediate
pc_d_i, pc_plus4_d_i  in  DATA_WIDTH  instruction PC, PC+4
rs1_d_i, rs2_d_i, rd_d_i  in  REG_ADDR_WIDTH  register indices
All of the above also exist as *_e_o outputs (same widths), plus valid_e_o  out  1.

Behaviour:
- Reset is synchronous and active-high, on the clk rising edge. It loads the bubble state.
- Bubble state: valid=0; reg_write, mem_write, jump, branch, alu_src = 0; result_src=00; alu_control=ALU_OP_ADD; funct3=000; op_a_sel=ALU_A_SRC_RS1; pc_target_src_sel=PC_TARGET_SRC_PC_PLUS_IMM; all data and index fields = 0.
- Priority per edge: rst > flush_e_i > stall_e_i > load.
  - flush: load bubble, even if stall is asserted in the same cycle.
  - stall (no flush): every field holds, including valid.
  - load: every *_e_o = corresponding *_d_i one cycle later (latency 1). valid_e_o = valid_d_i.
- Gating on invalid entries: if valid_d_i=0 on a load, the side-effect controls (reg_write, mem_write, jump, branch) are captured as 0, regardless of inputs. Data fields are captured as-is.
- Invariant: valid_e_o=0 implies reg_write_e_o=mem_write_e_o=jump_e_o=branch_e_o=0.
- No combinational path from any input to any output; all outputs are registered.
- Stall held for N cycles keeps outputs constant for N cycles. Release resumes loading on the next edge.
- rst asserted mid-stall or mid-flush takes effect on that edge. Outputs are the bubble state from the following cycle.

Decomposition:
- Shared package (common control-signals defines): alu_a_src_sel_e, pc_target_src_sel_e, and a new id_ex_ctrl_t packed struct bundling the control fields plus a bubble constant ID_EX_CTRL_BUBBLE. The bubble constant is reused by ex_mem/mem_wb stages.
- ALU_CONTROL_WIDTH and ALU_OP_ADD come from the ALU defines.
- One natural sub-module: pipe_stage_reg #(WIDTH, RESET_VAL). It is a generic register with sync reset, clear (loads RESET_VAL) and enable. It is instantiated once for the control struct (RESET_VAL = bubble) and once for the data/index bundle.

Test Plan:
1. Reset: rst=1 for 2 cycles with random inputs -> all outputs equal bubble state; valid_e_o=0, alu_control_e_o=ALU_OP_ADD.
2. Pass-through: load add x3,x1,x2 (reg_write=1, rd=3, rd1=0x5, rd2=0x7, pc=0x100, valid=1) -> next cycle rd_e_o=3, rd1_e_o=0x5, pc_e_o=0x100, reg_write_e_o=1, valid_e_o=1.
3. Stall: after test 2, stall=1 for 3 cycles with new inputs (rd=9) -> rd_e_o stays 3 for all 3 cycles. Release -> rd_e_o=9 next cycle.
4. Flush beats stall: store with mem_write=1 loaded, then flush=1 and stall=1 together -> next cycle mem_write_e_o=0, valid_e_o=0, pc_e_o=0.
5. Invalid capture: valid_d_i=0 with jump=1, branch=1, reg_write=1, imm=0xFFC -> jump/branch/reg_write_e_o=0, imm_ext_e_o=0xFFC.
6. Back-to-back stream: 8 consecutive loads with incrementing pc (0x0..0x1C), no stall/flush -> pc_e_o sequence lags the inputs by exactly 1 cycle, with no drops or duplicates.

Source files
------------

// File: rtl/id_ex_pipeline_reg_pkg.sv
// Shared control-signal definitions for the RV32I pipeline.
// Holds ALU op codes, operand/target selects and the ID/EX control bundle.
package id_ex_pipeline_reg_pkg;

    // ALU operation encoding
    localparam int ALU_CONTROL_WIDTH = 4;

    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_OP_ADD  = 4'b0000;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_OP_SUB  = 4'b0001;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_OP_AND  = 4'b0010;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_OP_OR   = 4'b0011;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_OP_XOR  = 4'b0100;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_OP_SLT  = 4'b0101;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_OP_SLTU = 4'b0110;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_OP_SLL  = 4'b0111;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_OP_SRL  = 4'b1000;
    localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_OP_SRA  = 4'b1001;

    // Writeback result source
    localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
    localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

    // ALU operand A source
    typedef enum logic [1:0] {
        ALU_A_SRC_RS1  = 2'b00,
        ALU_A_SRC_PC   = 2'b01,
        ALU_A_SRC_ZERO = 2'b10
    } alu_a_src_sel_e;

    // Branch/jump target adder base
    typedef enum logic {
        PC_TARGET_SRC_PC_PLUS_IMM  = 1'b0,
        PC_TARGET_SRC_RS1_PLUS_IMM = 1'b1
    } pc_target_src_sel_e;

    // Control bundle carried from decode into execute
    typedef struct packed {
        logic                         valid;
        logic                         reg_write;
        logic [1:0]                   result_src;
        logic                         mem_write;
        logic                         jump;
        logic                         branch;
        logic                         alu_src;
        logic [ALU_CONTROL_WIDTH-1:0] alu_control;
        logic [2:0]                   funct3;
        alu_a_src_sel_e               op_a_sel;
        pc_target_src_sel_e           pc_target_src_sel;
    } id_ex_ctrl_t;

    // A harmless no-op: nothing written, no redirect, ALU adds rs1+rs2
    localparam id_ex_ctrl_t ID_EX_CTRL_BUBBLE = '{
        valid:             1'b0,
        reg_write:         1'b0,
        result_src:        RESULT_SRC_ALU,
        mem_write:         1'b0,
        jump:              1'b0,
        branch:            1'b0,
        alu_src:           1'b0,
        alu_control:       ALU_OP_ADD,
        funct3:            3'b000,
        op_a_sel:          ALU_A_SRC_RS1,
        pc_target_src_sel: PC_TARGET_SRC_PC_PLUS_IMM
    };

    // Strip architectural side effects from an entry that is not valid
    function automatic id_ex_ctrl_t ctrl_squash(input id_ex_ctrl_t c);
        id_ex_ctrl_t r;
        r = c;
        if (!c.valid) begin
            r.reg_write = 1'b0;
            r.mem_write = 1'b0;
            r.jump      = 1'b0;
            r.branch    = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/id_ex_pipeline_reg_pipe_stage_reg.sv
// Generic pipeline register with synchronous reset, clear and enable.
// Reset and clear both load RESET_VAL; clear outranks enable.
module pipe_stage_reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Priority: reset, then clear, then enabled load, else hold
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_q <= RESET_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// Decode-to-execute pipeline register of the 5-stage RV32I core.
// Splits state into a control bundle (bubble on reset/flush) and data.
module id_ex_pipeline_reg
    import id_ex_pipeline_reg_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall_e_i,
    input  logic                         flush_e_i,
    input  logic                         valid_d_i,
    input  logic                         reg_write_d_i,
    input  logic [1:0]                   result_src_d_i,
    input  logic                         mem_write_d_i,
    input  logic                         jump_d_i,
    input  logic                         branch_d_i,
    input  logic                         alu_src_d_i,
    input  logic [ALU_CONTROL_WIDTH-1:0] alu_control_d_i,
    input  logic [2:0]                   funct3_d_i,
    input  alu_a_src_sel_e               op_a_sel_d_i,
    input  pc_target_src_sel_e           pc_target_src_sel_d_i,
    input  logic [DATA_WIDTH-1:0]        rd1_d_i,
    input  logic [DATA_WIDTH-1:0]        rd2_d_i,
    input  logic [DATA_WIDTH-1:0]        imm_ext_d_i,
    input  logic [DATA_WIDTH-1:0]        pc_d_i,
    input  logic [DATA_WIDTH-1:0]        pc_plus4_d_i,
    input  logic [REG_ADDR_WIDTH-1:0]    rs1_d_i,
    input  logic [REG_ADDR_WIDTH-1:0]    rs2_d_i,
    input  logic [REG_ADDR_WIDTH-1:0]    rd_d_i,
    output logic                         valid_e_o,
    output logic                         reg_write_e_o,
    output logic [1:0]                   result_src_e_o,
    output logic                         mem_write_e_o,
    output logic                         jump_e_o,
    output logic                         branch_e_o,
    output logic                         alu_src_e_o,
    output logic [ALU_CONTROL_WIDTH-1:0] alu_control_e_o,
    output logic [2:0]                   funct3_e_o,
    output alu_a_src_sel_e               op_a_sel_e_o,
    output pc_target_src_sel_e           pc_target_src_sel_e_o,
    output logic [DATA_WIDTH-1:0]        rd1_e_o,
    output logic [DATA_WIDTH-1:0]        rd2_e_o,
    output logic [DATA_WIDTH-1:0]        imm_ext_e_o,
    output logic [DATA_WIDTH-1:0]        pc_e_o,
    output logic [DATA_WIDTH-1:0]        pc_plus4_e_o,
    output logic [REG_ADDR_WIDTH-1:0]    rs1_e_o,
    output logic [REG_ADDR_WIDTH-1:0]    rs2_e_o,
    output logic [REG_ADDR_WIDTH-1:0]    rd_e_o
);

    localparam int CTRL_W = $bits(id_ex_ctrl_t);
    localparam int DATA_W = 5 * DATA_WIDTH + 3 * REG_ADDR_WIDTH;

    id_ex_ctrl_t       w_ctrl_raw;
    id_ex_ctrl_t       w_ctrl_d;
    id_ex_ctrl_t       w_ctrl_e;
    logic [DATA_W-1:0] w_data_d;
    logic [DATA_W-1:0] w_data_e;
    logic              w_en;

    assign w_en = ~stall_e_i;

    assign w_ctrl_raw = '{
        valid:             valid_d_i,
        reg_write:         reg_write_d_i,
        result_src:        result_src_d_i,
        mem_write:         mem_write_d_i,
        jump:              jump_d_i,
        branch:            branch_d_i,
        alu_src:           alu_src_d_i,
        alu_control:       alu_control_d_i,
        funct3:            funct3_d_i,
        op_a_sel:          op_a_sel_d_i,
        pc_target_src_sel: pc_target_src_sel_d_i
    };

    // Invalid entries may not write, store or redirect downstream
    assign w_ctrl_d = ctrl_squash(w_ctrl_raw);

    assign w_data_d = {
        rd1_d_i,
        rd2_d_i,
        imm_ext_d_i,
        pc_d_i,
        pc_plus4_d_i,
        rs1_d_i,
        rs2_d_i,
        rd_d_i
    };

    pipe_stage_reg #(
        .WIDTH     (CTRL_W),
        .RESET_VAL (ID_EX_CTRL_BUBBLE)
    ) u_ctrl_reg (
        .clk     (clk),
        .rst     (rst),
        .i_clear (flush_e_i),
        .i_en    (w_en),
        .i_d     (w_ctrl_d),
        .o_q     (w_ctrl_e)
    );

    pipe_stage_reg #(
        .WIDTH     (DATA_W),
        .RESET_VAL ('0)
    ) u_data_reg (
        .clk     (clk),
        .rst     (rst),
        .i_clear (flush_e_i),
        .i_en    (w_en),
        .i_d     (w_data_d),
        .o_q     (w_data_e)
    );

    assign valid_e_o             = w_ctrl_e.valid;
    assign reg_write_e_o         = w_ctrl_e.reg_write;
    assign result_src_e_o        = w_ctrl_e.result_src;
    assign mem_write_e_o         = w_ctrl_e.mem_write;
    assign jump_e_o              = w_ctrl_e.jump;
    assign branch_e_o            = w_ctrl_e.branch;
    assign alu_src_e_o           = w_ctrl_e.alu_src;
    assign alu_control_e_o       = w_ctrl_e.alu_control;
    assign funct3_e_o            = w_ctrl_e.funct3;
    assign op_a_sel_e_o          = w_ctrl_e.op_a_sel;
    assign pc_target_src_sel_e_o = w_ctrl_e.pc_target_src_sel;

    assign {
        rd1_e_o,
        rd2_e_o,
        imm_ext_e_o,
        pc_e_o,
        pc_plus4_e_o,
        rs1_e_o,
        rs2_e_o,
        rd_e_o
    } = w_data_e;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Self-checking bench for id_ex_pipeline_reg.
// Vector table plus scoreboard queue; random stall/flush tail.
module tb_id_ex_pipeline_reg;
    import id_ex_pipeline_reg_pkg::*;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic [1:0]  result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        logic [3:0]  alu_control;
        logic [2:0]  funct3;
        logic [1:0]  op_a_sel;
        logic        pc_tgt;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } bun_t;

    typedef struct {
        string       name;
        logic        rst;
        logic        stall;
        logic        flush;
        bun_t        in;
        logic        chk;
        logic        e_valid;
        logic        e_regw;
        logic        e_memw;
        logic        e_jump;
        logic        e_branch;
        logic [31:0] e_pc;
        logic [4:0]  e_rd;
        logic [31:0] e_imm;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic stall;
    logic flush;
    bun_t din;
    bun_t dout;

    alu_a_src_sel_e     op_a_d;
    alu_a_src_sel_e     op_a_e;
    pc_target_src_sel_e pt_d;
    pc_target_src_sel_e pt_e;

    logic        valid_e, regw_e, memw_e, jump_e, branch_e, alusrc_e;
    logic [1:0]  rsrc_e;
    logic [3:0]  aluc_e;
    logic [2:0]  f3_e;
    logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc4_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;

    int   n_chk  = 0;
    int   n_fail = 0;
    bun_t m;
    bun_t q[$];
    vec_t tbl[22];

    always #5 clk = ~clk;

    assign op_a_d = alu_a_src_sel_e'(din.op_a_sel);
    assign pt_d   = pc_target_src_sel_e'(din.pc_tgt);

    assign dout = {valid_e, regw_e, rsrc_e, memw_e, jump_e, branch_e,
                   alusrc_e, aluc_e, f3_e, op_a_e, pt_e,
                   rd1_e, rd2_e, imm_e, pc_e, pc4_e, rs1_e, rs2_e, rd_e};

    id_ex_pipeline_reg #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .stall_e_i             (stall),
        .flush_e_i             (flush),
        .valid_d_i             (din.valid),
        .reg_write_d_i         (din.reg_write),
        .result_src_d_i        (din.result_src),
        .mem_write_d_i         (din.mem_write),
        .jump_d_i              (din.jump),
        .branch_d_i            (din.branch),
        .alu_src_d_i           (din.alu_src),
        .alu_control_d_i       (din.alu_control),
        .funct3_d_i            (din.funct3),
        .op_a_sel_d_i          (op_a_d),
        .pc_target_src_sel_d_i (pt_d),
        .rd1_d_i               (din.rd1),
        .rd2_d_i               (din.rd2),
        .imm_ext_d_i           (din.imm),
        .pc_d_i                (din.pc),
        .pc_plus4_d_i          (din.pc4),
        .rs1_d_i               (din.rs1),
        .rs2_d_i               (din.rs2),
        .rd_d_i                (din.rd),
        .valid_e_o             (valid_e),
        .reg_write_e_o         (regw_e),
        .result_src_e_o        (rsrc_e),
        .mem_write_e_o         (memw_e),
        .jump_e_o              (jump_e),
        .branch_e_o            (branch_e),
        .alu_src_e_o           (alusrc_e),
        .alu_control_e_o       (aluc_e),
        .funct3_e_o            (f3_e),
        .op_a_sel_e_o          (op_a_e),
        .pc_target_src_sel_e_o (pt_e),
        .rd1_e_o               (rd1_e),
        .rd2_e_o               (rd2_e),
        .imm_ext_e_o           (imm_e),
        .pc_e_o                (pc_e),
        .pc_plus4_e_o          (pc4_e),
        .rs1_e_o               (rs1_e),
        .rs2_e_o               (rs2_e),
        .rd_e_o                (rd_e)
    );

    function automatic bun_t bubble();
        bun_t b;
        b             = '0;
        b.alu_control = ALU_OP_ADD;
        b.op_a_sel    = ALU_A_SRC_RS1;
        b.pc_tgt      = PC_TARGET_SRC_PC_PLUS_IMM;
        return b;
    endfunction

    function automatic bun_t rnd();
        bun_t b;
        b.valid       = 1'($urandom);
        b.reg_write   = 1'($urandom);
        b.result_src  = 2'($urandom_range(0, 2));
        b.mem_write   = 1'($urandom);
        b.jump        = 1'($urandom);
        b.branch      = 1'($urandom);
        b.alu_src     = 1'($urandom);
        b.alu_control = 4'($urandom_range(1, 9));
        b.funct3      = 3'($urandom);
        b.op_a_sel    = 2'($urandom_range(0, 2));
        b.pc_tgt      = 1'($urandom);
        b.rd1         = $urandom;
        b.rd2         = $urandom;
        b.imm         = $urandom;
        b.pc          = $urandom;
        b.pc4         = $urandom;
        b.rs1         = 5'($urandom);
        b.rs2         = 5'($urandom);
        b.rd          = 5'($urandom);
        return b;
    endfunction

    function automatic bun_t ins(bit v, bit rw, bit mw, bit j, bit br,
                                 logic [31:0] pc, logic [4:0] rd,
                                 logic [31:0] imm);
        bun_t b;
        b           = rnd();
        b.valid     = v;
        b.reg_write = rw;
        b.mem_write = mw;
        b.jump      = j;
        b.branch    = br;
        b.pc        = pc;
        b.pc4       = pc + 32'd4;
        b.rd        = rd;
        b.imm       = imm;
        return b;
    endfunction

    function automatic vec_t mkv(string nm, bit r, bit s, bit f, bun_t in,
                                 bit c, bit ev, bit er, bit em, bit ej,
                                 bit eb, logic [31:0] epc,
                                 logic [4:0] erd, logic [31:0] eimm);
        vec_t v;
        v.name     = nm;
        v.rst      = r;
        v.stall    = s;
        v.flush    = f;
        v.in       = in;
        v.chk      = c;
        v.e_valid  = ev;
        v.e_regw   = er;
        v.e_memw   = em;
        v.e_jump   = ej;
        v.e_branch = eb;
        v.e_pc     = epc;
        v.e_rd     = erd;
        v.e_imm    = eimm;
        return v;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(vec_t v);
        bun_t e;
        bun_t g;
        @(negedge clk);
        rst   = v.rst;
        stall = v.stall;
        flush = v.flush;
        din   = v.in;
        if (v.rst || v.flush) begin
            m = bubble();
        end else if (!v.stall) begin
            g = v.in;
            if (!g.valid) begin
                g.reg_write = 1'b0;
                g.mem_write = 1'b0;
                g.jump      = 1'b0;
                g.branch    = 1'b0;
            end
            m = g;
        end
        q.push_back(m);
        @(posedge clk);
        #1;
        n_chk++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", v.name);
        end else begin
            e = q.pop_front();
            if (dout !== e) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", v.name, dout, e);
            end
        end
        if (v.chk) begin
            check({v.name, ".valid"},  32'(valid_e),  32'(v.e_valid));
            check({v.name, ".regw"},   32'(regw_e),   32'(v.e_regw));
            check({v.name, ".memw"},   32'(memw_e),   32'(v.e_memw));
            check({v.name, ".jump"},   32'(jump_e),   32'(v.e_jump));
            check({v.name, ".branch"}, 32'(branch_e), 32'(v.e_branch));
            check({v.name, ".pc"},     pc_e,          v.e_pc);
            check({v.name, ".rd"},     32'(rd_e),     32'(v.e_rd));
            check({v.name, ".imm"},    imm_e,         v.e_imm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bun_t b;
        int   ns;
        m     = bubble();
        rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        din   = rnd();

        tbl[0] = mkv("reset0", 1, 1, 0, ins(1, 1, 1, 1, 1, 32'h44, 5'd4, 32'h9),
                     1, 0, 0, 0, 0, 0, 32'h0, 5'd0, 32'h0);
        tbl[1] = mkv("reset1", 1, 0, 0, ins(1, 1, 0, 1, 0, 32'h48, 5'd5, 32'h8),
                     1, 0, 0, 0, 0, 0, 32'h0, 5'd0, 32'h0);
        b = ins(1, 1, 0, 0, 0, 32'h100, 5'd3, 32'h11);
        b.rd1 = 32'h5;
        b.rd2 = 32'h7;
        tbl[2] = mkv("add_x3", 0, 0, 0, b,
                     1, 1, 1, 0, 0, 0, 32'h100, 5'd3, 32'h11);
        b = ins(1, 1, 0, 0, 0, 32'h200, 5'd9, 32'h22);
        for (int i = 0; i < 3; i++) begin
            tbl[3+i] = mkv($sformatf("stall%0d", i), 0, 1, 0, b,
                           1, 1, 1, 0, 0, 0, 32'h100, 5'd3, 32'h11);
        end
        tbl[6] = mkv("release", 0, 0, 0, b,
                     1, 1, 1, 0, 0, 0, 32'h200, 5'd9, 32'h22);
        tbl[7] = mkv("store", 0, 0, 0, ins(1, 0, 1, 0, 0, 32'h300, 5'd0, 32'h33),
                     1, 1, 0, 1, 0, 0, 32'h300, 5'd0, 32'h33);
        tbl[8] = mkv("flush_stall", 0, 1, 1, ins(1, 1, 1, 1, 1, 32'h304, 5'd6, 32'h44),
                     1, 0, 0, 0, 0, 0, 32'h0, 5'd0, 32'h0);
        tbl[9] = mkv("invalid", 0, 0, 0, ins(0, 1, 1, 1, 1, 32'h400, 5'd7, 32'hFFC),
                     1, 0, 0, 0, 0, 0, 32'h400, 5'd7, 32'hFFC);
        for (int i = 0; i < 8; i++) begin
            b = ins(1, 1, 0, 0, 0, 32'(i * 4), 5'(i + 1), 32'(i + 100));
            tbl[10+i] = mkv($sformatf("stream%0d", i), 0, 0, 0, b,
                            1, 1, 1, 0, 0, 0, 32'(i * 4), 5'(i + 1), 32'(i + 100));
        end
        tbl[18] = mkv("load_a", 0, 0, 0, ins(1, 1, 0, 0, 1, 32'h500, 5'd10, 32'h55),
                      1, 1, 1, 0, 0, 1, 32'h500, 5'd10, 32'h55);
        tbl[19] = mkv("rst_stall", 1, 1, 0, ins(1, 1, 1, 1, 1, 32'h504, 5'd11, 32'h66),
                      1, 0, 0, 0, 0, 0, 32'h0, 5'd0, 32'h0);
        tbl[20] = mkv("load_b", 0, 0, 0, ins(1, 1, 0, 1, 0, 32'h600, 5'd12, 32'h77),
                      1, 1, 1, 0, 1, 0, 32'h600, 5'd12, 32'h77);
        tbl[21] = mkv("rst_flush", 1, 0, 1, ins(1, 1, 1, 1, 1, 32'h604, 5'd13, 32'h88),
                      1, 0, 0, 0, 0, 0, 32'h0, 5'd0, 32'h0);

        for (int i = 0; i < 22; i++) begin
            step(tbl[i]);
        end

        // long stall: load once, hold N cycles with changing inputs, release
        step(mkv("ls_load", 0, 0, 0, rnd(), 0, 0, 0, 0, 0, 0, 0, 0, 0));
        ns = $urandom_range(4, 7);
        for (int i = 0; i < ns; i++) begin
            step(mkv("ls_hold", 0, 1, 0, rnd(), 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        step(mkv("ls_release", 0, 0, 0, rnd(), 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // random mixed traffic
        for (int i = 0; i < 60; i++) begin
            step(mkv("rand", ($urandom_range(0, 19) == 0),
                     ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 7) == 0),
                     rnd(), 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end

        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d left expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
